// File: rtl/conv33_window.sv
// rtl/conv33_window.sv - 3x3 sliding window generator with two line buffers (optional stride 2 via CONV33_WIN_STRIDE2_EN)
module conv33_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]         data_0_0,
    output logic [DATA_WIDTH-1:0]         data_0_1,
    output logic [DATA_WIDTH-1:0]         data_0_2,
    output logic [DATA_WIDTH-1:0]         data_1_0,
    output logic [DATA_WIDTH-1:0]         data_1_1,
    output logic [DATA_WIDTH-1:0]         data_1_2,
    output logic [DATA_WIDTH-1:0]         data_2_0,
    output logic [DATA_WIDTH-1:0]         data_2_1,
    output logic [DATA_WIDTH-1:0]         data_2_2,
    output logic                          win_valid,
    output logic                          frame_done,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    // Position of the last emitted window; with stride 2 it is the last even offset from 2.
`ifdef CONV33_WIN_STRIDE2_EN
    localparam int LAST_R_I = 2 + 2 * ((IMG_HEIGHT - 3) / 2);
    localparam int LAST_C_I = 2 + 2 * ((IMG_WIDTH - 3) / 2);
`else
    localparam int LAST_R_I = IMG_HEIGHT - 1;
    localparam int LAST_C_I = IMG_WIDTH - 1;
`endif

    localparam logic [CW-1:0] COL_END   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_END   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WLAST = CW'(LAST_C_I);
    localparam logic [RW-1:0] ROW_WLAST = RW'(LAST_R_I);
    localparam logic [CW-1:0] COL_TWO   = CW'(2);
    localparam logic [RW-1:0] ROW_TWO   = RW'(2);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic                  r_win_valid;
    logic                  r_frame_done;
    logic [RW-1:0]         r_win_row;
    logic [CW-1:0]         r_win_col;

    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col_nxt;
    logic [RW-1:0]         w_row_nxt;
    logic                  w_win_en;
    logic                  w_last;
    logic [RW-1:0]         w_out_row;
    logic [CW-1:0]         w_out_col;
    logic [DATA_WIDTH-1:0] w_col_in [3];

    // Effective pixel position (sof forces 0,0), window qualification and next counter values.
    always_comb begin
        w_col     = in_sof ? '0 : r_col;
        w_row     = in_sof ? '0 : r_row;
        w_win_en  = (w_row >= ROW_TWO) && (w_col >= COL_TWO);
`ifdef CONV33_WIN_STRIDE2_EN
        // (row-2) even is the same as row even.
        w_win_en  = w_win_en && !w_row[0] && !w_col[0];
        w_out_row = (w_row - ROW_TWO) >> 1;
        w_out_col = (w_col - COL_TWO) >> 1;
`else
        w_out_row = w_row - ROW_TWO;
        w_out_col = w_col - COL_TWO;
`endif
        w_last    = w_win_en && (w_row == ROW_WLAST) && (w_col == COL_WLAST);
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_col == COL_END) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_END) ? '0 : w_row + RW'(1);
        end
        w_col_in[0] = r_lb1[w_col];
        w_col_in[1] = r_lb0[w_col];
        w_col_in[2] = in_data;
    end

    // Line buffers: age one row per accepted pixel; contents are never reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_data;
        end
    end

    // Position counters, window shift register and output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_win_valid  <= w_win_en;
            r_frame_done <= w_last;
            if (w_win_en) begin
                r_win_row <= w_out_row;
                r_win_col <= w_out_col;
            end
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_col_in[r];
            end
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign data_0_0   = r_win[0][0];
    assign data_0_1   = r_win[0][1];
    assign data_0_2   = r_win[0][2];
    assign data_1_0   = r_win[1][0];
    assign data_1_1   = r_win[1][1];
    assign data_1_2   = r_win[1][2];
    assign data_2_0   = r_win[2][0];
    assign data_2_1   = r_win[2][1];
    assign data_2_2   = r_win[2][2];
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;

endmodule
